y86_imem_loader: RTL and testbench

Byte-serial program loader and instruction memory for the Y86 pipelined processor. A host streams a length-prefixed program image over a valid/ready byte interface; the block writes it into an internal byte-addressed instruction memory, holding the processor in stall until loading completes. The same memory serves the fetch stage through a combinational 10-byte read port, so this block is the writer side of the instruction memory that fetch reads.

---
 rtl/y86_imem_loader.sv | 204 ++++++++++++++++++++
 tb/tb_y86_imem_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_imem_loader.sv
// y86_imem_loader: byte-serial program loader and instruction memory.
// A host streams LEN_LO, LEN_HI, N payload bytes (plus a checksum byte
// when IMEM_CHECKSUM_EN is defined) over in_valid/in_ready; bytes land
// at addresses 0..N-1 while cpu_hold stalls the pipeline.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_data    host byte stream, in_ready = loader accepts
//   reload              restart loading from DONE or ERR
//   cpu_hold/load_done  pipeline stall / image complete
//   err_len/err_csum    length too large / checksum mismatch
//   f_pc/f_instr        fetch read port: 10 bytes at f_pc
//   imem_error          fetch address out of range
// Optional feature macro: IMEM_CHECKSUM_EN.
module y86_imem_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        reload,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        err_len,
    output logic        err_csum,
    input  logic [63:0] f_pc,
    output logic [79:0] f_instr,
    output logic        imem_error
);

    localparam logic [15:0] MEM_N  = 16'(MEM_BYTES);
    localparam logic [63:0] PC_MAX = 64'(MEM_BYTES - 10);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef IMEM_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // State entered once the payload is complete.
`ifdef IMEM_CHECKSUM_EN
    localparam state_t S_END = S_CSUM;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  lo_q, lo_d;
    logic        err_len_q, err_len_d;
    logic        wr_en;
    logic        xfer;
    logic [15:0] n_hdr;

`ifdef IMEM_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic        err_csum_q, err_csum_d;
`endif

    logic [7:0] mem [0:MEM_BYTES-1];

    assign xfer  = in_valid && in_ready;
    assign n_hdr = {in_data, lo_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LEN_LO;
            addr_q     <= '0;
            len_q      <= '0;
            lo_q       <= '0;
            err_len_q  <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            sum_q      <= '0;
            err_csum_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            lo_q       <= lo_d;
            err_len_q  <= err_len_d;
`ifdef IMEM_CHECKSUM_EN
            sum_q      <= sum_d;
            err_csum_q <= err_csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        lo_d       = lo_q;
        err_len_d  = err_len_q;
`ifdef IMEM_CHECKSUM_EN
        sum_d      = sum_q;
        err_csum_d = err_csum_q;
`endif
        wr_en      = 1'b0;
        in_ready   = 1'b0;
        unique case (state_q)
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (xfer) begin
                    lo_d    = in_data;
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (xfer) begin
                    len_d  = n_hdr;
                    addr_d = '0;
`ifdef IMEM_CHECKSUM_EN
                    sum_d  = '0;
`endif
                    if (n_hdr > MEM_N) begin
                        state_d   = S_ERR;
                        err_len_d = 1'b1;
                    end else if (n_hdr == 16'd0) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (xfer) begin
                    wr_en = 1'b1;
`ifdef IMEM_CHECKSUM_EN
                    sum_d = 8'(sum_q + in_data);
`endif
                    // Hold the address on the last byte so it
                    // never reaches MEM_BYTES.
                    if (addr_q == len_q - 16'd1) begin
                        state_d = S_END;
                    end else begin
                        addr_d = addr_q + 16'd1;
                    end
                end
            end
`ifdef IMEM_CHECKSUM_EN
            S_CSUM: begin
                in_ready = 1'b1;
                if (xfer) begin
                    if (8'(sum_q + in_data) == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ERR;
                        err_csum_d = 1'b1;
                    end
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (reload) begin
                    state_d    = S_LEN_LO;
                    err_len_d  = 1'b0;
`ifdef IMEM_CHECKSUM_EN
                    err_csum_d = 1'b0;
`endif
                end
            end
            default: state_d = S_LEN_LO;
        endcase
    end

    assign load_done = (state_q == S_DONE);
    assign cpu_hold  = (state_q != S_DONE);
    assign err_len   = err_len_q;
`ifdef IMEM_CHECKSUM_EN
    assign err_csum  = err_csum_q;
`else
    assign err_csum  = 1'b0;
`endif

    // Memory has no reset: old contents survive reset and reload.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_q[ADDR_W-1:0]] <= in_data;
        end
    end

    always_comb begin
        imem_error = (f_pc > PC_MAX);
        f_instr    = '0;
        if (!imem_error) begin
            for (int i = 0; i < 10; i++) begin
                f_instr[8*i +: 8] =
                    mem[f_pc[ADDR_W-1:0] + ADDR_W'(i)];
            end
        end
    end

endmodule

// File: tb/tb_y86_imem_loader.sv
// Testbench for y86_imem_loader: directed frames, fetch table,
// random valid gaps checked against a byte-level reference model.
module tb_y86_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        reload;
    logic        cpu_hold;
    logic        load_done;
    logic        err_len;
    logic        err_csum;
    logic [63:0] f_pc;
    logic [79:0] f_instr;
    logic        imem_error;

    int nchk  = 0;
    int npass = 0;

    logic [7:0] mm    [1024];
    bit         known [1024];
    logic [7:0] img   [1024];

`ifdef IMEM_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef struct {
        logic [63:0] pc;
        logic        err;
        logic [7:0]  b0;
    } fvec_t;

    fvec_t ftab [7];

    y86_imem_loader #(
        .MEM_BYTES(1024),
        .ADDR_W   (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reload    (reload),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .err_len   (err_len),
        .err_csum  (err_csum),
        .f_pc      (f_pc),
        .f_instr   (f_instr),
        .imem_error(imem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        chk("push_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic send_img(input int n);
        logic [7:0] s;
        logic [15:0] n16;
        s   = 8'd0;
        n16 = 16'(n);
        push(n16[7:0]);
        push(n16[15:8]);
        for (int i = 0; i < n; i++) begin
            push(img[i]);
            mm[i]    = img[i];
            known[i] = 1'b1;
            s        = 8'(s + img[i]);
        end
`ifdef IMEM_CHECKSUM_EN
        push(8'(8'd0 - s));
`endif
    endtask

    task automatic chk_fetch(input string nm, input logic [63:0] pc);
        logic [79:0] exp;
        logic [79:0] msk;
        int idx;
        exp  = '0;
        msk  = '0;
        f_pc = pc;
        @(negedge clk);
        if (pc > 64'd1014) begin
            chk({nm, "_err"}, imem_error, 1);
            chk(nm, f_instr, 0);
        end else begin
            chk({nm, "_err"}, imem_error, 0);
            for (int i = 0; i < 10; i++) begin
                idx = int'(pc[9:0]) + i;
                if (known[idx]) begin
                    exp[8*i +: 8] = mm[idx];
                    msk[8*i +: 8] = 8'hFF;
                end
            end
            chk(nm, f_instr & msk, exp);
        end
    endtask

    initial begin
        logic [7:0] sbuf [19];
        logic [7:0] s;
        int  k;
        int  tot;
        bit  md;
        bit  acc;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        reload   = 1'b0;
        f_pc     = 64'd0;
        for (int i = 0; i < 1024; i++) known[i] = 1'b0;

        // Fetch vectors after a full image with mem[a] = 7a+3.
        ftab[0] = '{64'd0,                  1'b0, 8'h03};
        ftab[1] = '{64'd500,                1'b0, 8'hAF};
        ftab[2] = '{64'd1009,               1'b0, 8'h9A};
        ftab[3] = '{64'd1014,               1'b0, 8'hBD};
        ftab[4] = '{64'd1015,               1'b1, 8'h00};
        ftab[5] = '{64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 8'h00};
        ftab[6] = '{64'h1_0000_0000,        1'b1, 8'h00};

        // Reset state
        #12;
        chk("rst_ready", in_ready, 1);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_done", load_done, 0);
        chk("rst_elen", err_len, 0);
        chk("rst_ecsum", err_csum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", in_ready, 1);
        chk("rel_hold", cpu_hold, 1);

        // Test-plan frame 05 00 30 F2 0A 00 00
        push(8'h05);
        push(8'h00);
        push(8'h30);
        chk("wr_latency", f_instr[7:0], 8'h30);
        push(8'hF2);
        push(8'h0A);
        push(8'h00);
        chk("done_early", load_done, 0);
        push(8'h00);
`ifdef IMEM_CHECKSUM_EN
        chk("done_early_cs", load_done, 0);
        push(8'hD4);
`endif
        mm[0] = 8'h30; mm[1] = 8'hF2; mm[2] = 8'h0A;
        mm[3] = 8'h00; mm[4] = 8'h00;
        for (int i = 0; i < 5; i++) known[i] = 1'b1;
        chk("f1_done", load_done, 1);
        chk("f1_hold", cpu_hold, 0);
        chk("f1_ready", in_ready, 0);
        chk("f1_instr", f_instr[39:0], 40'h00000AF230);

        // Bytes offered in DONE are not consumed
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (3) tick();
        chk("done_hold_ld", load_done, 1);
        chk("done_hold_mem", f_instr[39:0], 40'h00000AF230);
        in_valid = 1'b0;

        // Oversized length
        do_reload();
        chk("rl_done", load_done, 0);
        chk("rl_hold", cpu_hold, 1);
        chk("rl_ready", in_ready, 1);
        push(8'h01);
        push(8'h04);
        chk("elen", err_len, 1);
        chk("elen_ready", in_ready, 0);
        chk("elen_hold", cpu_hold, 1);
        chk("elen_done", load_done, 0);
        do_reload();
        chk("elen_clr", err_len, 0);
        chk("elen_rl_ready", in_ready, 1);

        // Random valid gaps and ignored reload over a 16-byte image
        tot     = 18 + CS;
        sbuf[0] = 8'd16;
        sbuf[1] = 8'd0;
        s       = 8'd0;
        for (int i = 0; i < 16; i++) begin
            sbuf[i+2] = 8'($urandom);
            s         = 8'(s + sbuf[i+2]);
        end
        sbuf[18] = 8'(8'd0 - s);
        k  = 0;
        md = 1'b0;
        for (int cyc = 0; cyc < 400 && !md; cyc++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = sbuf[k];
            reload   = ($urandom_range(0, 3) == 0);
            chk("rand_ready", in_ready, 1);
            acc = in_valid;
            tick();
            if (acc) begin
                if (k >= 2 && k < 18) begin
                    mm[k-2]    = sbuf[k];
                    known[k-2] = 1'b1;
                end
                k++;
                if (k == tot) md = 1'b1;
            end
            chk("rand_done", load_done, md);
            chk("rand_hold", cpu_hold, !md);
        end
        in_valid = 1'b0;
        reload   = 1'b0;
        chk("rand_timeout", load_done, 1);
        chk_fetch("rand_f0", 64'd0);
        chk_fetch("rand_f6", 64'd6);

        // Full memory image, N == MEM_BYTES
        do_reload();
        for (int a = 0; a < 1024; a++) img[a] = 8'(a * 7 + 3);
        send_img(1024);
        chk("full_done", load_done, 1);
        chk("full_elen", err_len, 0);
        for (int i = 0; i < 7; i++) begin
            f_pc = ftab[i].pc;
            @(negedge clk);
            chk("ftab_err", imem_error, ftab[i].err);
            if (ftab[i].err) chk("ftab_zero", f_instr, 0);
            else chk("ftab_b0", f_instr[7:0], ftab[i].b0);
        end
        for (int i = 0; i < 4; i++) begin
            chk_fetch("full_rand", 64'($urandom_range(0, 1014)));
        end

        // Empty image
        do_reload();
        send_img(0);
        chk("n0_done", load_done, 1);
        chk("n0_hold", cpu_hold, 0);

        // Asynchronous reset mid-frame
        do_reload();
        push(8'h08);
        push(8'h00);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        mm[0] = 8'hA1; mm[1] = 8'hA2; mm[2] = 8'hA3;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ready", in_ready, 1);
        chk("ar_hold", cpu_hold, 1);
        chk("ar_done", load_done, 0);
        chk("ar_elen", err_len, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        img[0] = 8'h55;
        img[1] = 8'h66;
        send_img(2);
        chk("ar_reload_done", load_done, 1);
        chk_fetch("ar_fetch", 64'd0);

`ifdef IMEM_CHECKSUM_EN
        do_reload();
        push(8'h02); push(8'h00); push(8'h10);
        push(8'h20); push(8'hD0);
        mm[0] = 8'h10; mm[1] = 8'h20;
        chk("cs_ok_done", load_done, 1);
        chk("cs_ok_err", err_csum, 0);
        do_reload();
        push(8'h02); push(8'h00); push(8'h10);
        push(8'h20); push(8'hD1);
        chk("cs_bad_err", err_csum, 1);
        chk("cs_bad_hold", cpu_hold, 1);
        chk("cs_bad_done", load_done, 0);
        do_reload();
        chk("cs_bad_clr", err_csum, 0);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
